// File: rtl/hi_ssp_rx_deframer.sv
// hi_ssp_rx_deframer: recovers 16-bit I/Q reports from the correlator SSP stream into a 2-entry valid/ready FIFO.
// Optional out_amp estimator enabled by HI_SSP_RX_AMPLITUDE_EN.
module hi_ssp_rx_deframer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       ssp_clk,
    input  logic       ssp_frame,
    input  logic       ssp_din,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_i,
    output logic [7:0] out_q,
    output logic [8:0] out_amp,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic [7:0] sync_err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state_q;
    logic          s1_clk_q, s1_frame_q, s1_din_q, s2_clk_q;
    logic [4:0]    cnt_q;
    logic [15:0]   sr_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;
    logic [7:0]    err_q;
    logic [15:0]   e0_q, e1_q, e0_d, e1_d;
    logic [1:0]    fcnt_q, fcnt_d, cnt_pop;
    logic          ovf_q;
    logic          strobe, pop, acc, drop;
    logic [7:0]    err_inc;
    assign strobe  = s2_clk_q & ~s1_clk_q;
    assign err_inc = err_q + {7'd0, err_q != 8'hFF};
    // push_q is a registered FSM output; sr_q holds the finished word while it is pushed
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            {s1_clk_q, s1_frame_q, s1_din_q, s2_clk_q} <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            tmo_q   <= '0;
            push_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            s1_clk_q   <= ssp_clk;
            s1_frame_q <= ssp_frame;
            s1_din_q   <= ssp_din;
            s2_clk_q   <= s1_clk_q;
            push_q     <= 1'b0;
            if (state_q == IDLE) begin
                tmo_q <= '0;
                if (strobe && s1_frame_q) begin
                    sr_q    <= {15'd0, s1_din_q};
                    cnt_q   <= 5'd1;
                    state_q <= SHIFT;
                end
            end else if (strobe && s1_frame_q) begin
                sr_q  <= {15'd0, s1_din_q};
                cnt_q <= 5'd1;
                tmo_q <= '0;
                err_q <= err_inc;
            end else if (strobe) begin
                sr_q  <= {sr_q[14:0], s1_din_q};
                cnt_q <= cnt_q + 5'd1;
                tmo_q <= '0;
                if (cnt_q == 5'd15) begin
                    push_q  <= 1'b1;
                    state_q <= IDLE;
                end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= IDLE;
                err_q   <= err_inc;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end
    // Head always sits in e0; an emptying pop leaves e0 untouched so outputs hold the last report
    assign out_valid = fcnt_q != 2'd0;
    assign pop       = out_valid & out_ready;
    assign acc       = push_q & (fcnt_q != 2'd2 | pop);
    assign drop      = push_q & ~acc;
    assign cnt_pop   = fcnt_q - {1'b0, pop};
    assign fcnt_d    = cnt_pop + {1'b0, acc};
    assign e0_d      = (acc && cnt_pop == 2'd0) ? sr_q : (pop && fcnt_q == 2'd2) ? e1_q : e0_q;
    assign e1_d      = (acc && cnt_pop == 2'd1) ? sr_q : e1_q;
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            e0_q   <= '0;
            e1_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= drop | (ovf_q & ~clr_overflow);
        end
    end
    assign out_i        = e0_q[15:8];
    assign out_q        = e0_q[7:0];
    assign overflow     = ovf_q;
    assign sync_err_cnt = err_q;
`ifdef HI_SSP_RX_AMPLITUDE_EN
    logic signed [8:0] si, sq;
    logic [8:0]        ai, aq, mx, mn;
    always_comb begin
        si = {e0_q[15], e0_q[15:8]};
        sq = {e0_q[7], e0_q[7:0]};
        ai = si[8] ? 9'(-si) : 9'(si);
        aq = sq[8] ? 9'(-sq) : 9'(sq);
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
    end
    assign out_amp = mx + (mn >> 1);
`else
    assign out_amp = '0;
`endif
endmodule

// File: tb/tb_hi_ssp_rx_deframer.sv
// tb_hi_ssp_rx_deframer: directed SSP frames with hand-computed expectations.
module tb_hi_ssp_rx_deframer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ssp_clk = 1'b0, ssp_frame = 1'b0, ssp_din = 1'b0;
    logic       out_valid, out_ready = 1'b0, overflow, clr_overflow = 1'b0;
    logic [7:0] out_i, out_q, sync_err_cnt;
    logic [8:0] out_amp;
    int         n_vec = 0, n_err = 0;

    hi_ssp_rx_deframer dut (
        .ck_1356meg(clk), .reset(reset), .ssp_clk(ssp_clk), .ssp_frame(ssp_frame),
        .ssp_din(ssp_din), .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
        .out_q(out_q), .out_amp(out_amp), .overflow(overflow), .clr_overflow(clr_overflow),
        .sync_err_cnt(sync_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bits hi..lo of w, MSB first; frame accompanies bit 15; ssp_clk = clk/4
    task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            ssp_clk = 1'b1; ssp_din = w[i]; ssp_frame = (i == 15);
            repeat (2) @(negedge clk);
            ssp_clk = 1'b0;
            repeat (2) @(negedge clk);
        end
        ssp_frame = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(w, 15, 0);
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_i", out_i, 0);
        check("rst_q", out_q, 0);
        check("rst_amp", out_amp, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", sync_err_cnt, 0);

        // 1: reset mid-word, remainder of the word arrives without frame
        send_bits(16'hBEEF, 15, 8);
        do_reset();
        check("t1_valid_rst", out_valid, 0);
        check("t1_err_rst", sync_err_cnt, 0);
        send_bits(16'hBEEF, 7, 0);
        repeat (4) @(negedge clk);
        check("t1_valid", out_valid, 0);
        check("t1_err", sync_err_cnt, 0);
        check("t1_ovf", overflow, 0);
        check("t1_i", out_i, 0);

        // 2: single frame, latency and one-beat handshake
        out_ready = 1'b1;
        send_word(16'h5AC3);
        check("t2_valid_early", out_valid, 0);
        @(negedge clk);
        check("t2_valid", out_valid, 1);
        check("t2_i", out_i, 16'h5A);
        check("t2_q", out_q, 16'hC3);
`ifdef HI_SSP_RX_AMPLITUDE_EN
        check("t2_amp", out_amp, 120);
`else
        check("t2_amp", out_amp, 0);
`endif
        @(negedge clk);
        check("t2_single_beat", out_valid, 0);
        check("t2_hold_i", out_i, 16'h5A);
        out_ready = 1'b0;

        // 3: overflow on third word, drain, clear
        send_word(16'h0101);
        send_word(16'h0202);
        repeat (2) @(negedge clk);
        check("t3_ovf_two", overflow, 0);
        send_word(16'h0303);
        repeat (2) @(negedge clk);
        check("t3_ovf", overflow, 1);
        check("t3_valid", out_valid, 1);
        check("t3_head_i", out_i, 16'h01);
        check("t3_head_q", out_q, 16'h01);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_second_valid", out_valid, 1);
        check("t3_second_i", out_i, 16'h02);
        check("t3_second_q", out_q, 16'h02);
        @(negedge clk);
        out_ready = 1'b0;
        check("t3_drained", out_valid, 0);
        check("t3_hold_q", out_q, 16'h02);
        check("t3_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // 4: frame re-asserted after 7 bits
        send_bits(16'hFFFF, 15, 9);
        send_word(16'h7F80);
        repeat (2) @(negedge clk);
        check("t4_err", sync_err_cnt, 1);
        check("t4_valid", out_valid, 1);
        check("t4_i", out_i, 16'h7F);
        check("t4_q", out_q, 16'h80);
        pop1();
        check("t4_popped", out_valid, 0);

        // 5: ssp_clk stall mid-word
        do_reset();
        send_bits(16'hAAAA, 15, 11);
        repeat (20) @(negedge clk);
        check("t5_err", sync_err_cnt, 1);
        check("t5_valid", out_valid, 0);
        send_word(16'h1234);
        repeat (2) @(negedge clk);
        check("t5_valid_next", out_valid, 1);
        check("t5_i", out_i, 16'h12);
        check("t5_q", out_q, 16'h34);
        check("t5_err_after", sync_err_cnt, 1);
        pop1();

        // 6: amplitude estimate
        send_word(16'h40E0);
        repeat (2) @(negedge clk);
`ifdef HI_SSP_RX_AMPLITUDE_EN
        check("t6_amp_a", out_amp, 80);
`else
        check("t6_amp_a", out_amp, 0);
`endif
        pop1();
        send_word(16'h8000);
        repeat (2) @(negedge clk);
        check("t6_i", out_i, 16'h80);
`ifdef HI_SSP_RX_AMPLITUDE_EN
        check("t6_amp_b", out_amp, 128);
`else
        check("t6_amp_b", out_amp, 0);
`endif
        pop1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
